// File: rtl/serial_in_parallel_out_reg_pkg.sv
// Shared definitions for the serial link shift registers. The bit-order
// encoding is common to the transmit (parallel-in) and receive (serial-in)
// ends so both sides agree on what shift_left_right means.
package serial_in_parallel_out_reg_pkg;

  // Bit-order select values carried on shift_left_right.
  localparam logic ORDER_MSB_FIRST = 1'b0;  // left shift, MSB arrives first
  localparam logic ORDER_LSB_FIRST = 1'b1;  // right shift, LSB arrives first

  // Narrowest counter that can index every bit position of a word.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage : serial_in_parallel_out_reg_pkg

// File: rtl/serial_in_parallel_out_reg.sv
// Serial-in / parallel-out receive register. Assembles WIDTH-bit words one
// qualified bit per clock in either bit order. Each completed word goes into
// a one-word holding register and is handed off with a valid/ready
// handshake. When a word completes while the holding register is still full
// and is not being drained, that word is dropped and the sticky overrun flag
// is raised.
module serial_in_parallel_out_reg
  import serial_in_parallel_out_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             shift_left_right,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [CNT_W-1:0] cnt;
  logic             dir_q;
  logic             order;
  logic             shift_en;
  logic             word_done;
  logic             consume;
  logic             load;

  // Pick this bit's order (fresh from the input on the first bit of a word,
  // latched afterwards) and form the post-shift register value.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    order   = dir_q;
    sr_next = {sr[WIDTH-2:0], sin};
    if (cnt == '0) begin
      order = shift_left_right;
    end
    if (order == ORDER_LSB_FIRST) begin
      sr_next = {sin, sr[WIDTH-1:1]};
    end
  end

  // clear takes priority over an incoming bit, so an abort on the last-bit
  // edge produces no word and cannot raise overrun.
  assign shift_en  = sin_valid & ~clear;
  assign word_done = shift_en & (cnt == CNT_LAST);
  assign consume   = q_valid & q_ready;
  // A finishing word can enter the holding register if it is empty or is
  // being drained on this same edge.
  assign load      = word_done & (~q_valid | q_ready);
  assign busy      = (cnt != '0);

  // Word assembly: shift register, bit counter and latched bit order.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      sr    <= '0;
      cnt   <= '0;
      dir_q <= ORDER_MSB_FIRST;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (sin_valid) begin
      sr    <= sr_next;
      dir_q <= order;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Output holding register, consumer handshake and sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        q       <= sr_next;
        q_valid <= 1'b1;
      end else if (consume) begin
        q_valid <= 1'b0;
      end

      if (clear) begin
        overrun <= 1'b0;
      end else if (word_done && !load) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule : serial_in_parallel_out_reg

// File: tb/tb_serial_in_parallel_out_reg.sv
// Self-checking bench for serial_in_parallel_out_reg (WIDTH=8). A reference
// model keeps the partial word as a queue of received bits and forms each
// finished word arithmetically; words it expects to be loaded are pushed on
// a scoreboard queue that a separate monitor pops whenever the consumer
// takes q.
module tb_serial_in_parallel_out_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         sin;
  logic         sin_valid;
  logic         shift_left_right;
  logic         clear;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready;
  logic         busy;
  logic         overrun;

  serial_in_parallel_out_reg #(.WIDTH(W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sin              (sin),
    .sin_valid        (sin_valid),
    .shift_left_right (shift_left_right),
    .clear            (clear),
    .q                (q),
    .q_valid          (q_valid),
    .q_ready          (q_ready),
    .busy             (busy),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  bit           part[$];   // bits of the word in progress, in arrival order
  bit           m_order;
  bit           m_qv;
  bit           m_ovr;
  logic [W-1:0] exp_q[$];  // scoreboard: words expected out of q, in order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    part.delete();
    exp_q.delete();
    m_order = 1'b0;
    m_qv    = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs presented on it.
  task automatic model_step();
    bit consume;
    bit loaded;
    int unsigned word;
    consume = m_qv && q_ready;
    loaded  = 1'b0;
    if (clear) begin
      part.delete();
      m_ovr = 1'b0;
    end else if (sin_valid) begin
      if (part.size() == 0) m_order = shift_left_right;
      part.push_back(sin);
      if (part.size() == W) begin
        word = 0;
        for (int i = 0; i < W; i++) begin
          if (m_order == 1'b0) word = word * 2 + 32'(part[i]);
          else                 word = word + (32'(part[i]) << i);
        end
        part.delete();
        if (!m_qv || q_ready) begin
          exp_q.push_back(word[W-1:0]);
          loaded = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    if (loaded)       m_qv = 1'b1;
    else if (consume) m_qv = 1'b0;
  endtask

  // One clock: inputs already applied; outputs settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset_n) model_step();
  endtask

  task automatic drive(input logic s, input logic v, input logic d, input logic c, input logic r);
    sin = s; sin_valid = v; shift_left_right = d; clear = c; q_ready = r;
    tick();
  endtask

  task automatic idle(input logic r, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, r);
  endtask

  // Send one full word; shift_left_right flips from bit index flip_at on
  // (negative = never); the last bit uses rdy_last for q_ready.
  task automatic send_word(input logic [W-1:0] w, input logic ord, input logic rdy,
                           input logic rdy_last, input int flip_at);
    logic b;
    logic d;
    for (int i = 0; i < W; i++) begin
      b = ord ? w[i] : w[W-1-i];
      d = (flip_at >= 0 && i >= flip_at) ? ~ord : ord;
      drive(b, 1'b1, d, 1'b0, (i == W-1) ? rdy_last : rdy);
    end
    sin_valid = 1'b0;
  endtask

  // Monitor: compares status against the model and pops the scoreboard on
  // each consume, sampling mid-cycle away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("busy", 32'(busy), 32'(part.size() != 0));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("q_valid", 32'(q_valid), 32'(m_qv));
        if (q_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_q: got %0h with q_valid, expected no word at %0t", q, $time);
          end else begin
            check("sb_q", 32'(q), 32'(exp_q[0]));
            if (q_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    reset_n = 1'b0;
    sin = 1'b0; sin_valid = 1'b0; shift_left_right = 1'b0; clear = 1'b0; q_ready = 1'b0;
    #2;
    check("rst_q", 32'(q), 32'h0);
    check("rst_q_valid", 32'(q_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1'b1, 2);

    // MSB-first A5 with q_ready held: one-cycle q_valid pulse.
    send_word(8'hA5, 1'b0, 1'b1, 1'b1, -1);
    check("msb_a5_q", 32'(q), 32'hA5);
    check("msb_a5_valid", 32'(q_valid), 32'h1);
    idle(1'b1, 1);
    check("msb_a5_pulse", 32'(q_valid), 32'h0);

    // LSB-first words.
    send_word(8'hA5, 1'b1, 1'b1, 1'b1, -1);
    check("lsb_a5_q", 32'(q), 32'hA5);
    send_word(8'h3C, 1'b1, 1'b1, 1'b1, -1);
    check("lsb_3c_q", 32'(q), 32'h3C);
    idle(1'b1, 1);

    // Order latched at word start; later flips ignored.
    send_word(8'h96, 1'b0, 1'b1, 1'b1, 3);
    check("latch_96_q", 32'(q), 32'h96);
    idle(1'b1, 1);

    // Overrun: second word dropped, clear drops the flag but keeps q.
    send_word(8'h11, 1'b0, 1'b0, 1'b0, -1);
    send_word(8'h22, 1'b0, 1'b0, 1'b0, -1);
    check("ovr_q", 32'(q), 32'h11);
    check("ovr_valid", 32'(q_valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_ovr", 32'(overrun), 32'h0);
    check("clr_q", 32'(q), 32'h11);
    check("clr_valid", 32'(q_valid), 32'h1);
    idle(1'b1, 1);

    // Abort after 5 bits, then a fresh word.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("abort_busy", 32'(busy), 32'h0);
    send_word(8'hC3, 1'b0, 1'b1, 1'b1, -1);
    check("abort_c3_q", 32'(q), 32'hC3);
    idle(1'b1, 1);

    // Completion coinciding with clear: no word, no overrun.
    for (int i = 0; i < W-1; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("clrlast_valid", 32'(q_valid), 32'h0);
    check("clrlast_ovr", 32'(overrun), 32'h0);

    // Completion coinciding with consume is a load.
    send_word(8'h55, 1'b0, 1'b0, 1'b0, -1);
    send_word(8'hAA, 1'b0, 1'b0, 1'b1, -1);
    check("cc_q", 32'(q), 32'hAA);
    check("cc_valid", 32'(q_valid), 32'h1);
    check("cc_ovr", 32'(overrun), 32'h0);

    // Reset mid-word with a pending word held: outputs clear at once.
    q_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_q", 32'(q), 32'h0);
    check("mid_rst_valid", 32'(q_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_ovr", 32'(overrun), 32'h0);
    model_reset();
    idle(1'b0, 1);
    reset_n = 1'b1;
    idle(1'b1, 1);

    // Randomized traffic against the model and scoreboard.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)));
    end
    idle(1'b1, 3);
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_serial_in_parallel_out_reg
